// File: rtl/nios_system_gpio_0_out_pkg.sv
// Shared definitions for the output PIO with one-shot pulse engine.
//   - Register address constants for the Avalon-MM slave.
//   - Bit positions inside the STATUS register.
//   - Pulse engine state encoding.
//   - Avalon write-strobe qualification helper.
package nios_system_gpio_0_out_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_PULSE  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int BUSY  = 0;
    localparam int IRQEN = 1;
    localparam int DONE  = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_e;

    // A write happens only when the slave is selected and write_n is low.
    function automatic logic is_write(input logic cs, input logic wn);
        return cs & ~wn;
    endfunction

endpackage

// File: rtl/nios_system_gpio_0_out_pulse.sv
// Pulse engine: down-counter plus IDLE/PULSE state machine.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   load, value   - start/restart a pulse of `value` clocks (0 = stop)
//   abort         - return to IDLE and clear the counter
//   busy          - registered state is PULSE
//   busy_next     - state after the coming edge (lets the top register
//                   out_port without an extra cycle of lag)
//   cnt           - remaining pulse clocks
//   done_pulse    - high in the cycle whose edge ends a pulse naturally
module nios_system_gpio_0_out_pulse
    import nios_system_gpio_0_out_pkg::*;
#(
    parameter int CNT_WIDTH = 16
)
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] value,
    input  logic                 abort,
    output logic                 busy,
    output logic                 busy_next,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 done_pulse
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 done_s;

    // Next state and count; abort beats load, load beats natural expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_s  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
        end else if (load) begin
            if (value != CNT_ZERO) begin
                state_d = PULSE;
                cnt_d   = value;
            end else begin
                // Zero length: no-op when idle, stops a running pulse.
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        end else begin
            case (state_q)
                PULSE: begin
                    if (cnt_q == CNT_ONE) begin
                        state_d = IDLE;
                        cnt_d   = CNT_ZERO;
                        done_s  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                IDLE: begin
                    state_d = IDLE;
                    cnt_d   = cnt_q;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy       = (state_q == PULSE);
    assign busy_next  = (state_d == PULSE);
    assign cnt        = cnt_q;
    assign done_pulse = done_s;

endmodule

// File: rtl/nios_system_gpio_0_out.sv
// Avalon-MM output PIO with a one-shot pulse engine.
// Registers: 0 DATA, 1 MASK (bits inverted while pulsing),
//            2 PULSE (write N = pulse for N clocks, read = remaining),
//            3 STATUS (bit0 busy / write 1 aborts).
// Optional macro NIOS_SYSTEM_GPIO_0_OUT_IRQ_EN adds STATUS bit1 IRQEN,
// bit2 DONE (sticky, write 1 to clear) and the registered `irq` port.
// Ports:
//   clk, reset_n           - clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata     - Avalon-MM slave write/select inputs
//   readdata               - registered read data (1 cycle latency)
//   out_port               - registered DATA ^ (pulsing ? MASK : 0)
//   irq                    - DONE & IRQEN (only with the macro)
module nios_system_gpio_0_out
    import nios_system_gpio_0_out_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}},
    parameter int                    CNT_WIDTH   = 16
)
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
`ifdef NIOS_SYSTEM_GPIO_0_OUT_IRQ_EN
    ,
    output logic                  irq
`endif
);

    logic                  wr_s;
    logic                  load_s;
    logic                  abort_s;
    logic                  busy_s;
    logic                  busy_next_s;
    logic [CNT_WIDTH-1:0]  cnt_s;
    logic                  done_pulse_s;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] out_port_q, out_port_d;
    logic [31:0]           readdata_q, readdata_d;

    assign wr_s    = is_write(chipselect, write_n);
    assign load_s  = wr_s && (address == ADDR_PULSE);
    assign abort_s = wr_s && (address == ADDR_STATUS) && writedata[BUSY];

    nios_system_gpio_0_out_pulse #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_pulse (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load_s),
        .value      (writedata[CNT_WIDTH-1:0]),
        .abort      (abort_s),
        .busy       (busy_s),
        .busy_next  (busy_next_s),
        .cnt        (cnt_s),
        .done_pulse (done_pulse_s)
    );

`ifdef NIOS_SYSTEM_GPIO_0_OUT_IRQ_EN
    logic irqen_q, irqen_d;
    logic done_q,  done_d;
    logic irq_q,   irq_d;
    logic unused_s;

    // Interrupt enable, sticky DONE (a set beats a same-cycle clear) and irq.
    always_comb begin
        irqen_d = irqen_q;
        done_d  = done_q;
        if (wr_s && (address == ADDR_STATUS)) begin
            irqen_d = writedata[IRQEN];
        end else begin
            irqen_d = irqen_q;
        end
        if (done_pulse_s) begin
            done_d = 1'b1;
        end else if (wr_s && (address == ADDR_STATUS) && writedata[DONE]) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
        irq_d = done_d & irqen_d;
    end

    // Interrupt registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqen_q <= 1'b0;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            irqen_q <= irqen_d;
            done_q  <= done_d;
            irq_q   <= irq_d;
        end
    end

    assign irq      = irq_q;
    assign unused_s = &{1'b0, writedata};
`else
    logic unused_s;
    assign unused_s = &{1'b0, writedata, done_pulse_s};
`endif

    // DATA/MASK writes and the pin value; uses next-cycle values so that a
    // write or pulse start shows on out_port right after its own edge.
    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        if (wr_s && (address == ADDR_DATA)) begin
            data_d = writedata[DATA_WIDTH-1:0];
        end else begin
            data_d = data_q;
        end
        if (wr_s && (address == ADDR_MASK)) begin
            mask_d = writedata[DATA_WIDTH-1:0];
        end else begin
            mask_d = mask_q;
        end
        out_port_d = data_d ^ (busy_next_s ? mask_d : {DATA_WIDTH{1'b0}});
    end

    // Read mux of current register contents, zero-extended; chipselect ignored.
    always_comb begin
        readdata_d = 32'd0;
        case (address)
            ADDR_DATA:   readdata_d[DATA_WIDTH-1:0] = data_q;
            ADDR_MASK:   readdata_d[DATA_WIDTH-1:0] = mask_q;
            ADDR_PULSE:  readdata_d[CNT_WIDTH-1:0]  = cnt_s;
            ADDR_STATUS: begin
                readdata_d[BUSY] = busy_s;
`ifdef NIOS_SYSTEM_GPIO_0_OUT_IRQ_EN
                readdata_d[IRQEN] = irqen_q;
                readdata_d[DONE]  = done_q;
`endif
            end
            default:     readdata_d = 32'd0;
        endcase
    end

    // Register file, pin and read-data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            mask_q     <= {DATA_WIDTH{1'b0}};
            out_port_q <= RESET_VALUE;
            readdata_q <= 32'd0;
        end else begin
            data_q     <= data_d;
            mask_q     <= mask_d;
            out_port_q <= out_port_d;
            readdata_q <= readdata_d;
        end
    end

    assign out_port = out_port_q;
    assign readdata = readdata_q;

endmodule
